// File: rtl/magic_pkg.sv
// Shared constants for the magic answer selector: bus configuration,
// register offsets and the pick FSM state encoding.
package magic_pkg;

   typedef struct packed {
      int unsigned IdWidth;
   } obi_cfg_t;

   localparam obi_cfg_t SbrObiCfg = '{IdWidth: 32'd4};

   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_RESULT = 2'd2;
   localparam logic [1:0] REG_COUNT  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } calc_state_e;

endpackage

// File: rtl/serial_mod.sv
// Bit-serial restoring modulo: one quotient bit per cycle, MSB first,
// leaving dividend mod NUM_ANSWERS in the remainder register.
module serial_mod
   import magic_pkg::*;
#(
   parameter int PRNG_WIDTH  = 32,
   parameter int NUM_ANSWERS = 20
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  start_i,
   input  logic [PRNG_WIDTH-1:0] dividend_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [5:0]            remainder_o
);

   localparam int              CNT_W     = $clog2(PRNG_WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(PRNG_WIDTH - 1);
   localparam logic [5:0]       MODULUS   = 6'(NUM_ANSWERS);

   calc_state_e           state_q, state_d;
   logic [PRNG_WIDTH-1:0] div_q, div_d;
   logic [5:0]            rem_q, rem_d, rem_shift_s;
   logic [CNT_W-1:0]      cnt_q, cnt_d;

   // Next-state and datapath step for the IDLE -> CALC -> DONE sequence
   always_comb begin
      state_d     = state_q;
      div_d       = div_q;
      rem_d       = rem_q;
      cnt_d       = cnt_q;
      rem_shift_s = {rem_q[4:0], div_q[PRNG_WIDTH-1]};
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               div_d   = dividend_i;
               rem_d   = 6'd0;
               cnt_d   = '0;
               state_d = ST_CALC;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CALC: begin
            div_d = {div_q[PRNG_WIDTH-2:0], 1'b0};
            cnt_d = cnt_q + CNT_W'(1);
            if (rem_shift_s >= MODULUS) begin
               rem_d = rem_shift_s - MODULUS;
            end else begin
               rem_d = rem_shift_s;
            end
            if (cnt_q == LAST_STEP) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_CALC;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         div_q   <= '0;
         rem_q   <= 6'd0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
      end
   end

   assign busy_o      = (state_q != ST_IDLE);
   assign done_o      = (state_q == ST_DONE);
   assign remainder_o = rem_q;

endmodule

// File: rtl/magic_answer_sel.sv
// OBI-attached selector that reduces a pseudo-random number modulo
// NUM_ANSWERS and exposes status, result and a completed-pick counter.
module magic_answer_sel
   import magic_pkg::*;
#(
   parameter int PRNG_WIDTH     = 32,
   parameter int NUM_ANSWERS    = 20,
   parameter int ADDR_WIDTH_OBI = 32,
   parameter int DATA_WIDTH_OBI = 32,
   parameter int ID_WIDTH_OBI   = SbrObiCfg.IdWidth
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      req_i,
   input  logic                      we_i,
   input  logic [3:0]                be_i,
   input  logic [ADDR_WIDTH_OBI-1:0] addr_i,
   input  logic [DATA_WIDTH_OBI-1:0] wdata_i,
   input  logic [ID_WIDTH_OBI-1:0]   aid_i,
   output logic                      gnt_o,
   output logic                      rvalid_o,
   output logic [DATA_WIDTH_OBI-1:0] rdata_o,
   output logic [ID_WIDTH_OBI-1:0]   rid_o,
   output logic                      err_o,
   input  logic [PRNG_WIDTH-1:0]     prn_i,
   output logic [4:0]                answer_idx_o,
   output logic                      answer_valid_o
);

   logic [1:0]  reg_sel_s;
   logic        start_req_s, start_s, busy_s, calc_done_s;
   logic [5:0]  rem_s;
   logic        unused_s;

   logic                      rvalid_q, rvalid_d;
   logic                      err_q, err_d;
   logic [DATA_WIDTH_OBI-1:0] rdata_q, rdata_d;
   logic [ID_WIDTH_OBI-1:0]   rid_q, rid_d;
   logic [4:0]                answer_idx_q, answer_idx_d;
   logic                      answer_valid_q, answer_valid_d;
   logic                      done_q, done_d;
   logic [15:0]               pick_cnt_q, pick_cnt_d;

   assign reg_sel_s   = addr_i[3:2];
   assign start_req_s = req_i && we_i && (reg_sel_s == REG_CTRL) && wdata_i[0];
   assign start_s     = start_req_s && !busy_s;
   assign gnt_o       = req_i;
   assign unused_s    = ^{be_i, addr_i[ADDR_WIDTH_OBI-1:4], addr_i[1:0],
                          wdata_i[DATA_WIDTH_OBI-1:1], rem_s[5]};

   serial_mod #(
      .PRNG_WIDTH (PRNG_WIDTH),
      .NUM_ANSWERS(NUM_ANSWERS)
   ) u_serial_mod (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .start_i    (start_s),
      .dividend_i (prn_i),
      .busy_o     (busy_s),
      .done_o     (calc_done_s),
      .remainder_o(rem_s)
   );

   // Bus response: decode access, flag illegal ones, build read data
   always_comb begin
      rvalid_d = req_i;
      rid_d    = '0;
      err_d    = 1'b0;
      rdata_d  = '0;
      if (req_i) begin
         rid_d = aid_i;
         if (we_i) begin
            err_d = (reg_sel_s != REG_CTRL) || (start_req_s && busy_s);
         end else begin
            case (reg_sel_s)
               REG_STATUS: rdata_d = DATA_WIDTH_OBI'({done_q, busy_s});
               REG_RESULT: rdata_d = DATA_WIDTH_OBI'(answer_idx_q);
               REG_COUNT:  rdata_d = DATA_WIDTH_OBI'(pick_cnt_q);
               default:    err_d   = 1'b1;
            endcase
         end
      end else begin
         rid_d = '0;
      end
   end

   // Result capture, sticky done and pick counter
   always_comb begin
      answer_idx_d   = answer_idx_q;
      answer_valid_d = calc_done_s;
      done_d         = done_q;
      pick_cnt_d     = pick_cnt_q;
      if (start_s) begin
         done_d = 1'b0;
      end else if (calc_done_s) begin
         answer_idx_d = rem_s[4:0];
         done_d       = 1'b1;
         pick_cnt_d   = pick_cnt_q + 16'd1;
      end else begin
         done_d = done_q;
      end
   end

   // Register bank
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rvalid_q       <= 1'b0;
         err_q          <= 1'b0;
         rdata_q        <= '0;
         rid_q          <= '0;
         answer_idx_q   <= 5'd0;
         answer_valid_q <= 1'b0;
         done_q         <= 1'b0;
         pick_cnt_q     <= 16'd0;
      end else begin
         rvalid_q       <= rvalid_d;
         err_q          <= err_d;
         rdata_q        <= rdata_d;
         rid_q          <= rid_d;
         answer_idx_q   <= answer_idx_d;
         answer_valid_q <= answer_valid_d;
         done_q         <= done_d;
         pick_cnt_q     <= pick_cnt_d;
      end
   end

   assign rvalid_o       = rvalid_q;
   assign err_o          = err_q;
   assign rdata_o        = rdata_q;
   assign rid_o          = rid_q;
   assign answer_idx_o   = answer_idx_q;
   assign answer_valid_o = answer_valid_q;

endmodule

// File: tb/tb_magic_answer_sel.sv
// Directed bench for magic_answer_sel: bus protocol, modulo results,
// busy/error handling, mid-computation reset and counter wrap.
module tb_magic_answer_sel;
   import magic_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        req_i = 1'b0;
   logic        we_i = 1'b0;
   logic [3:0]  be_i = 4'hF;
   logic [31:0] addr_i = 32'h0;
   logic [31:0] wdata_i = 32'h0;
   logic [3:0]  aid_i = 4'h0;
   logic        gnt_o, rvalid_o, err_o;
   logic [31:0] rdata_o;
   logic [3:0]  rid_o;
   logic [31:0] prn_i = 32'h0;
   logic [4:0]  answer_idx_o;
   logic        answer_valid_o;

   int total = 0;
   int bad   = 0;

   magic_answer_sel dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .req_i         (req_i),
      .we_i          (we_i),
      .be_i          (be_i),
      .addr_i        (addr_i),
      .wdata_i       (wdata_i),
      .aid_i         (aid_i),
      .gnt_o         (gnt_o),
      .rvalid_o      (rvalid_o),
      .rdata_o       (rdata_o),
      .rid_o         (rid_o),
      .err_o         (err_o),
      .prn_i         (prn_i),
      .answer_idx_o  (answer_idx_o),
      .answer_valid_o(answer_valid_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One bus transfer, issued just after a rising edge
   task automatic xact(input logic we, input logic [1:0] sel, input logic [31:0] wd,
                       input logic [3:0] id, output logic [31:0] rd, output logic er);
      req_i   = 1'b1;
      we_i    = we;
      addr_i  = {28'h0, sel, 2'b00};
      wdata_i = wd;
      aid_i   = id;
      #1 chk("gnt", {31'h0, gnt_o}, 32'h1);
      @(posedge clk_i); #1;
      req_i   = 1'b0;
      we_i    = 1'b0;
      wdata_i = 32'h0;
      aid_i   = 4'h0;
      chk("rvalid", {31'h0, rvalid_o}, 32'h1);
      chk("rid", {28'h0, rid_o}, {28'h0, id});
      rd = rdata_o;
      er = err_o;
      if (we) chk("wr_rdata_zero", rdata_o, 32'h0);
   endtask

   task automatic rd_chk(input string tag, input logic [1:0] sel, input logic [31:0] exp);
      logic [31:0] d;
      logic        e;
      xact(1'b0, sel, 32'h0, 4'h9, d, e);
      chk({tag, "_err"}, {31'h0, e}, 32'h0);
      chk(tag, d, exp);
   endtask

   task automatic start_pick(input logic [31:0] prn, input logic exp_err);
      logic [31:0] d;
      logic        e;
      prn_i = prn;
      xact(1'b1, REG_CTRL, 32'h1, 4'h3, d, e);
      chk("start_err", {31'h0, e}, {31'h0, exp_err});
   endtask

   task automatic wait_answer(output int cyc);
      cyc = 0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk_i); #1;
         if (answer_valid_o) begin
            cyc = i;
            break;
         end
      end
   endtask

   logic [31:0] prn_tab [6] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0029,
                                32'h0000_0014, 32'h0000_0013, 32'h8000_0000};
   logic [4:0]  exp_tab [6] = '{5'd15, 5'd0, 5'd1, 5'd0, 5'd19, 5'd8};

   initial begin
      int          cyc;
      int          seen;
      logic [31:0] d;
      logic        e;

      // reset holds every output low even with a request pending
      req_i = 1'b1;
      aid_i = 4'hF;
      repeat (3) @(posedge clk_i);
      #1;
      chk("rst_rvalid", {31'h0, rvalid_o}, 32'h0);
      chk("rst_err", {31'h0, err_o}, 32'h0);
      chk("rst_rid", {28'h0, rid_o}, 32'h0);
      chk("rst_rdata", rdata_o, 32'h0);
      chk("rst_idx", {27'h0, answer_idx_o}, 32'h0);
      chk("rst_valid", {31'h0, answer_valid_o}, 32'h0);
      req_i = 1'b0;
      aid_i = 4'h0;
      @(negedge clk_i) rst_ni = 1'b1;
      @(posedge clk_i); #1;
      rd_chk("status0", REG_STATUS, 32'h0);
      rd_chk("count0", REG_COUNT, 32'h0);

      // 0xDEADBEEF mod 20 = 19, valid 33 cycles after grant
      start_pick(32'hDEAD_BEEF, 1'b0);
      wait_answer(cyc);
      chk("latency", cyc, 32'd33);
      chk("idx_deadbeef", {27'h0, answer_idx_o}, 32'd19);
      @(posedge clk_i); #1;
      chk("valid_pulse", {31'h0, answer_valid_o}, 32'h0);
      rd_chk("result_deadbeef", REG_RESULT, 32'd19);
      rd_chk("count1", REG_COUNT, 32'd1);
      rd_chk("status_done", REG_STATUS, 32'h2);

      // back-to-back picks, each start in the cycle right after completion
      for (int k = 0; k < 6; k++) begin
         start_pick(prn_tab[k], 1'b0);
         wait_answer(cyc);
         chk("tab_latency", cyc, 32'd33);
         chk("tab_idx", {27'h0, answer_idx_o}, {27'h0, exp_tab[k]});
      end
      rd_chk("result_last", REG_RESULT, 32'd8);
      rd_chk("count7", REG_COUNT, 32'd7);

      // second start while busy, prn change mid-calc
      start_pick(32'h0000_0029, 1'b0);
      repeat (4) @(posedge clk_i);
      #1;
      start_pick(32'h0000_0029, 1'b1);
      prn_i = 32'hDEAD_BEEF;
      rd_chk("status_busy", REG_STATUS, 32'h1);
      wait_answer(cyc);
      chk("busy_latency", cyc, 32'd27);
      rd_chk("result_busy", REG_RESULT, 32'd1);
      rd_chk("count8", REG_COUNT, 32'd8);
      rd_chk("status_done2", REG_STATUS, 32'h2);
      xact(1'b1, REG_CTRL, 32'h0, 4'h2, d, e);
      chk("ctrl_nostart_err", {31'h0, e}, 32'h0);
      rd_chk("status_nostart", REG_STATUS, 32'h2);

      // illegal accesses
      xact(1'b1, REG_RESULT, 32'h1F, 4'h5, d, e);
      chk("wr_result_err", {31'h0, e}, 32'h1);
      xact(1'b0, REG_CTRL, 32'h0, 4'h6, d, e);
      chk("rd_ctrl_err", {31'h0, e}, 32'h1);
      chk("rd_ctrl_data", d, 32'h0);
      @(posedge clk_i); #1;
      chk("idle_rvalid", {31'h0, rvalid_o}, 32'h0);
      chk("idle_rdata", rdata_o, 32'h0);
      rd_chk("result_unchanged", REG_RESULT, 32'd1);

      // reset in the middle of a computation
      start_pick(32'h0000_0013, 1'b0);
      repeat (9) @(posedge clk_i);
      #1;
      rst_ni = 1'b0;
      #1;
      chk("midrst_idx", {27'h0, answer_idx_o}, 32'h0);
      chk("midrst_valid", {31'h0, answer_valid_o}, 32'h0);
      repeat (2) @(posedge clk_i);
      @(negedge clk_i) rst_ni = 1'b1;
      @(posedge clk_i); #1;
      rd_chk("midrst_status", REG_STATUS, 32'h0);
      rd_chk("midrst_count", REG_COUNT, 32'h0);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk_i); #1;
         if (answer_valid_o) seen++;
      end
      chk("midrst_no_pulse", seen, 32'd0);
      start_pick(32'hDEAD_BEEF, 1'b0);
      wait_answer(cyc);
      chk("post_rst_latency", cyc, 32'd33);
      chk("post_rst_idx", {27'h0, answer_idx_o}, 32'd19);
      rd_chk("post_rst_count", REG_COUNT, 32'd1);

      // counter wrap
      @(negedge clk_i) force dut.pick_cnt_q = 16'hFFFF;
      @(posedge clk_i);
      @(negedge clk_i) release dut.pick_cnt_q;
      @(posedge clk_i); #1;
      rd_chk("count_ffff", REG_COUNT, 32'h0000_FFFF);
      start_pick(32'h0000_0029, 1'b0);
      wait_answer(cyc);
      chk("wrap_latency", cyc, 32'd33);
      rd_chk("count_wrap", REG_COUNT, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
